// File: rtl/cam_i2c_sequencer_if.sv
// Command/handshake bus between the camera init/poll sequencer and the I2C master.
interface cam_i2c_sequencer_if;
    logic        i2c_ready;
    logic        i2c_start;
    logic [6:0]  i2c_addr;
    logic [15:0] i2c_data;
    logic [2:0]  i2c_packets;
    logic        i2c_rw;

    modport master (
        input  i2c_ready,
        output i2c_start, i2c_addr, i2c_data, i2c_packets, i2c_rw
    );

    modport slave (
        output i2c_ready,
        input  i2c_start, i2c_addr, i2c_data, i2c_packets, i2c_rw
    );
endinterface

// File: rtl/cam_i2c_sequencer.sv
// Camera I2C sequencer: writes a fixed init table once, then polls the sensor
// with a pointer-write / read pair every POLL_CYCLES, with a per-transaction
// timeout that restarts the whole sequence.
module cam_i2c_sequencer #(
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned POLL_CYCLES    = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned READ_PACKETS   = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    cam_i2c_sequencer_if.master        i2c,
    output logic                       init_done,
    output logic                       poll_valid,
    output logic                       timeout_err
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    localparam logic [TW-1:0] T_LIM     = TW'(TIMEOUT_CYCLES);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [2:0]    RD_PKTS   = 3'(READ_PACKETS);

    // Table index: 0..5 init writes, 6 poll pointer write, 7 poll read.
    localparam logic [2:0] IDX_LAST_INIT = 3'd5;
    localparam logic [2:0] IDX_POLL_WR   = 3'd6;
    localparam logic [2:0] IDX_POLL_RD   = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP,
        POLL_WAIT
    } state_t;

    state_t        state, state_n;
    logic [2:0]    idx, idx_n;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] gcnt;
    logic [PW-1:0] pcnt;
    logic          start_ok;
    logic          waiting;
    logic          tmo_hit;
    logic          in_txn;

    assign start_ok = (state == ISSUE) && i2c.i2c_ready;
    assign waiting  = (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign tmo_hit  = waiting && (tcnt == T_LIM);
    assign in_txn   = (state == ISSUE) || waiting;

    // State register and table index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    // Timeout, gap and poll-period counters plus the sticky init_done flag.
    // pcnt is loaded with 1 on the pointer-write start so that it reads k
    // exactly k cycles after that pulse; it saturates at POLL_CYCLES-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt      <= '0;
            gcnt      <= '0;
            pcnt      <= '0;
            init_done <= 1'b0;
        end else begin
            if (start_ok) begin
                tcnt <= TW'(1);
            end else if (waiting) begin
                if (tcnt != T_LIM) begin
                    tcnt <= tcnt + TW'(1);
                end
            end else begin
                tcnt <= '0;
            end

            if ((state == GAP) && (gcnt != GAP_LAST)) begin
                gcnt <= gcnt + GW'(1);
            end else begin
                gcnt <= '0;
            end

            if (start_ok && (idx == IDX_POLL_WR)) begin
                pcnt <= (POLL_LAST == '0) ? '0 : PW'(1);
            end else if (pcnt != POLL_LAST) begin
                pcnt <= pcnt + PW'(1);
            end

            if (tmo_hit) begin
                init_done <= 1'b0;
            end else if ((state == GAP) && (gcnt == GAP_LAST) && (idx == IDX_LAST_INIT)) begin
                init_done <= 1'b1;
            end
        end
    end

    // Next-state and next-index selection.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        unique case (state)
            IDLE: begin
                if (i2c.i2c_ready) begin
                    state_n = ISSUE;
                    idx_n   = '0;
                end
            end
            ISSUE: begin
                if (start_ok) begin
                    state_n = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tmo_hit) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else if (!i2c.i2c_ready) begin
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tmo_hit) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else if (i2c.i2c_ready) begin
                    state_n = GAP;
                end
            end
            GAP: begin
                if (gcnt == GAP_LAST) begin
                    if (idx == IDX_POLL_RD) begin
                        idx_n   = IDX_POLL_WR;
                        state_n = (pcnt == POLL_LAST) ? ISSUE : POLL_WAIT;
                    end else begin
                        idx_n   = idx + 3'd1;
                        state_n = ISSUE;
                    end
                end
            end
            POLL_WAIT: begin
                if (pcnt == POLL_LAST) begin
                    state_n = ISSUE;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    // Bus and status outputs; command fields are held only while a transaction is live.
    always_comb begin
        i2c.i2c_addr    = 7'h58;
        i2c.i2c_start   = start_ok;
        i2c.i2c_data    = '0;
        i2c.i2c_packets = '0;
        i2c.i2c_rw      = 1'b0;
        timeout_err     = tmo_hit;
        poll_valid      = (state == WAIT_DONE) && i2c.i2c_ready && !tmo_hit && (idx == IDX_POLL_RD);
        if (in_txn) begin
            case (idx)
                3'd0:    begin i2c.i2c_data = 16'h3001; i2c.i2c_packets = 3'd2; end
                3'd1:    begin i2c.i2c_data = 16'h3008; i2c.i2c_packets = 3'd2; end
                3'd2:    begin i2c.i2c_data = 16'h0690; i2c.i2c_packets = 3'd2; end
                3'd3:    begin i2c.i2c_data = 16'h08C0; i2c.i2c_packets = 3'd2; end
                3'd4:    begin i2c.i2c_data = 16'h1A40; i2c.i2c_packets = 3'd2; end
                3'd5:    begin i2c.i2c_data = 16'h3333; i2c.i2c_packets = 3'd2; end
                3'd6:    begin i2c.i2c_data = 16'h3600; i2c.i2c_packets = 3'd1; end
                default: begin i2c.i2c_packets = RD_PKTS; i2c.i2c_rw = 1'b1; end
            endcase
        end
    end
endmodule

// File: tb/tb_cam_i2c_sequencer.sv
// Self-checking bench for cam_i2c_sequencer: an I2C master model with random
// busy times, a transaction log, and a timeline reference model.
module tb_cam_i2c_sequencer;
    localparam int unsigned G  = 4;
    localparam int unsigned P  = 120;
    localparam int unsigned T  = 200;
    localparam int unsigned RP = 6;

    typedef struct {
        int unsigned cyc;
        logic [15:0] data;
        logic [2:0]  pkts;
        logic        rw;
        int unsigned lat;
    } txn_t;

    logic clk = 1'b0;
    logic reset;
    logic init_done, poll_valid, timeout_err;

    cam_i2c_sequencer_if bus();

    cam_i2c_sequencer #(
        .GAP_CYCLES(G),
        .POLL_CYCLES(P),
        .TIMEOUT_CYCLES(T),
        .READ_PACKETS(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i2c(bus.master),
        .init_done(init_done),
        .poll_valid(poll_valid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int unsigned nvec = 0, nfail = 0, viol = 0;
    int unsigned cyc = 0;
    txn_t        start_q[$];
    int unsigned pv_q[$];
    int unsigned to_q[$];
    int unsigned init_rise = 0;
    bit          init_seen = 0;

    // Master model state
    bit          force_low = 0, hung = 0, pend_hang = 0;
    int unsigned busy_left = 0, lat_fixed = 0, hang_on = 0, n_started = 0;

    // Per-cycle snapshot
    logic        m_start, m_ready, m_rw, m_init, m_pv, m_to;
    logic [6:0]  m_addr;
    logic [15:0] m_data;
    logic [2:0]  m_pkts;
    bit          prev_start = 0, in_txn = 0, seen_low = 0;
    logic [19:0] txn_bus;

    logic [15:0] init_tbl [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample and log at negedge, then update ready just after posedge.
    task automatic tick();
        int unsigned lat;
        lat = 0;
        @(negedge clk);
        m_start = bus.i2c_start;  m_ready = bus.i2c_ready;  m_addr = bus.i2c_addr;
        m_data  = bus.i2c_data;   m_pkts  = bus.i2c_packets; m_rw  = bus.i2c_rw;
        m_init  = init_done;      m_pv    = poll_valid;      m_to  = timeout_err;
        if (m_start === 1'b1 && m_ready !== 1'b1) viol++;
        if (m_start === 1'b1 && prev_start) viol++;
        if (m_addr !== 7'h58) viol++;
        if (in_txn) begin
            if ({m_data, m_pkts, m_rw} !== txn_bus) viol++;
            if (m_ready === 1'b0) seen_low = 1;
            else if (seen_low) in_txn = 0;
            if (m_to === 1'b1) in_txn = 0;
        end
        if (reset) in_txn = 0;
        if (m_start === 1'b1) begin
            if (lat_fixed != 0) lat = lat_fixed;
            else if (n_started < 6) lat = $urandom_range(30, 2);
            else if (((n_started - 6) / 2) % 2 == 1) lat = $urandom_range(70, 55);
            else lat = $urandom_range(30, 2);
            start_q.push_back('{cyc, m_data, m_pkts, m_rw, lat});
            n_started++;
            pend_hang = (n_started == hang_on);
            in_txn = 1; seen_low = 0; txn_bus = {m_data, m_pkts, m_rw};
        end
        if (m_pv === 1'b1) pv_q.push_back(cyc);
        if (m_to === 1'b1) to_q.push_back(cyc);
        if (m_init === 1'b1 && !init_seen) begin init_seen = 1; init_rise = cyc; end
        prev_start = (m_start === 1'b1);
        @(posedge clk);
        #1;
        cyc++;
        if (force_low) bus.i2c_ready = 1'b0;
        else if (m_start === 1'b1 && m_ready === 1'b1) begin
            bus.i2c_ready = 1'b0; busy_left = lat; hung = pend_hang;
        end else if (!bus.i2c_ready && !hung && busy_left > 1) busy_left--;
        else if (!hung) bus.i2c_ready = 1'b1;
    endtask

    task automatic wait_starts(input int unsigned n, input int unsigned budget, input string tag);
        int unsigned k;
        k = 0;
        while (start_q.size() < n && k < budget) begin tick(); k++; end
        chk(tag, 32'(start_q.size() >= n), 32'd1);
    endtask

    task automatic wait_timeout(input int unsigned budget, input string tag);
        int unsigned k;
        k = 0;
        while (to_q.size() < 1 && k < budget) begin tick(); k++; end
        chk(tag, 32'(to_q.size() >= 1), 32'd1);
    endtask

    // Reset the DUT, clear logs and master model; returns with reset released and ready high.
    task automatic restart(output int unsigned r);
        reset = 1'b1;
        tick(); tick();
        start_q.delete(); pv_q.delete(); to_q.delete();
        n_started = 0; in_txn = 0; prev_start = 0; init_seen = 0;
        hung = 0; busy_left = 0; force_low = 0;
        bus.i2c_ready = 1'b1;
        reset = 1'b0;
        r = cyc;
    endtask

    task automatic chk_reset_vals(input string ph);
        chk({ph, "_rst_start"}, 32'(m_start), 32'd0);
        chk({ph, "_rst_addr"},  32'(m_addr),  32'h58);
        chk({ph, "_rst_data"},  32'(m_data),  32'd0);
        chk({ph, "_rst_pkts"},  32'(m_pkts),  32'd0);
        chk({ph, "_rst_rw"},    32'(m_rw),    32'd0);
        chk({ph, "_rst_init"},  32'(m_init),  32'd0);
        chk({ph, "_rst_pv"},    32'(m_pv),    32'd0);
        chk({ph, "_rst_to"},    32'(m_to),    32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r, s1, k;
        int unsigned ec;
        logic [15:0] ed;
        logic [2:0]  ep;
        logic        er;
        init_tbl[0] = 16'h3001; init_tbl[1] = 16'h3008; init_tbl[2] = 16'h0690;
        init_tbl[3] = 16'h08C0; init_tbl[4] = 16'h1A40; init_tbl[5] = 16'h3333;

        // Phase A: reset values, ready held low, full init and four poll pairs.
        reset = 1'b1;
        force_low = 1;
        bus.i2c_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tick(); tick();
        chk_reset_vals("A");
        reset = 1'b0;
        repeat (50) tick();
        chk("A_no_start_ready_low", start_q.size(), 0);
        force_low = 0;
        bus.i2c_ready = 1'b1;
        r = cyc;
        wait_starts(14, 2500, "A_wait_starts");
        repeat (80) tick();
        if (start_q.size() >= 14) begin
            for (int i = 0; i < 14; i++) begin
                if (i < 6) begin ed = init_tbl[i]; ep = 3'd2; er = 1'b0; end
                else if ((i - 6) % 2 == 0) begin ed = 16'h3600; ep = 3'd1; er = 1'b0; end
                else begin ed = 16'h0000; ep = 3'(RP); er = 1'b1; end
                if (i == 0) ec = r + 1;
                else begin
                    ec = start_q[i-1].cyc + start_q[i-1].lat + G + 2;
                    if (i >= 8 && (i - 6) % 2 == 0 && start_q[i-2].cyc + P > ec)
                        ec = start_q[i-2].cyc + P;
                end
                chk($sformatf("A_data%0d", i), 32'(start_q[i].data), 32'(ed));
                chk($sformatf("A_pkts%0d", i), 32'(start_q[i].pkts), 32'(ep));
                chk($sformatf("A_rw%0d", i),   32'(start_q[i].rw),   32'(er));
                chk($sformatf("A_cyc%0d", i),  start_q[i].cyc,       ec);
            end
            chk("A_init_rise", init_rise, start_q[6].cyc);
            chk("A_pv_count", 32'(pv_q.size() >= 4), 32'd1);
            if (pv_q.size() >= 4) begin
                for (int j = 0; j < 4; j++) begin
                    k = 7 + 2 * j;
                    chk($sformatf("A_pv%0d", j), pv_q[j], start_q[k].cyc + start_q[k].lat + 1);
                end
            end
            chk("A_no_timeout", to_q.size(), 0);
        end

        // Phase B: master hangs on the 2nd init write.
        hang_on = 2;
        restart(r);
        wait_timeout(600, "B_wait_timeout");
        repeat (30) tick();
        chk("B_starts", start_q.size(), 2);
        if (start_q.size() >= 2 && to_q.size() >= 1) begin
            chk("B_s0_cyc",  start_q[0].cyc, r + 1);
            chk("B_s0_data", 32'(start_q[0].data), 32'h3001);
            chk("B_s1_cyc",  start_q[1].cyc, start_q[0].cyc + start_q[0].lat + G + 2);
            chk("B_s1_data", 32'(start_q[1].data), 32'h3008);
            chk("B_to_cyc",  to_q[0], start_q[1].cyc + T);
        end
        chk("B_to_once", to_q.size(), 1);
        chk("B_init_done", 32'(m_init), 32'd0);
        hung = 0;
        bus.i2c_ready = 1'b1;
        s1 = cyc;
        wait_starts(3, 20, "B_wait_restart");
        if (start_q.size() >= 3) begin
            chk("B_restart_cyc",  start_q[2].cyc, s1 + 1);
            chk("B_restart_data", 32'(start_q[2].data), 32'h3001);
        end

        // Phase B2: master hangs on the first poll read, after init_done is set.
        hang_on = 8;
        restart(r);
        wait_timeout(1500, "B2_wait_timeout");
        chk("B2_init_before", 32'(m_init), 32'd1);
        tick();
        chk("B2_init_cleared", 32'(m_init), 32'd0);
        if (start_q.size() >= 8 && to_q.size() >= 1) begin
            chk("B2_rd_rw", 32'(start_q[7].rw), 32'd1);
            chk("B2_to_cyc", to_q[0], start_q[7].cyc + T);
        end
        chk("B2_no_pv", pv_q.size(), 0);
        hung = 0;
        bus.i2c_ready = 1'b1;
        s1 = cyc;
        wait_starts(9, 20, "B2_wait_restart");
        if (start_q.size() >= 9) begin
            chk("B2_restart_cyc",  start_q[8].cyc, s1 + 1);
            chk("B2_restart_data", 32'(start_q[8].data), 32'h3001);
        end

        // Phase C: reset during WAIT_DONE of the 4th init write.
        hang_on = 0;
        lat_fixed = 20;
        restart(r);
        wait_starts(4, 400, "C_wait_4th");
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk_reset_vals("C");
        wait_starts(5, 100, "C_wait_restart");
        if (start_q.size() >= 5) begin
            chk("C_s3_data",      32'(start_q[3].data), 32'h08C0);
            chk("C_restart_data", 32'(start_q[4].data), 32'h3001);
            chk("C_restart_pkts", 32'(start_q[4].pkts), 32'd2);
            chk("C_restart_cyc",  start_q[4].cyc, start_q[3].cyc + 22);
        end
        repeat (10) tick();

        chk("protocol_monitor", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
